// File: rtl/alu_op_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Holds ALU inputs for EXEC_CYCLES, captures the result, then pulses the winner's response.
module alu_op_arbiter #(
  parameter int WIDTH       = 8,
  parameter int OPW         = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_s,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy,
  output logic             grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t     state_r;
  state_t     state_s;
  logic       last_grant_r;
  logic [3:0] cnt_r;
  logic       win_s;
  logic       win_valid_s;
  logic       hs_s;

  // Round-robin pick: on a tie the requester that did not own the last operation wins
  always_comb begin
    win_s       = 1'b0;
    win_valid_s = 1'b0;
    if (req0_valid && req1_valid) begin
      win_s       = ~last_grant_r;
      win_valid_s = 1'b1;
    end else if (req0_valid) begin
      win_s       = 1'b0;
      win_valid_s = 1'b1;
    end else if (req1_valid) begin
      win_s       = 1'b1;
      win_valid_s = 1'b1;
    end else begin
      win_s       = 1'b0;
      win_valid_s = 1'b0;
    end
  end

  // Ready is gated by rst so nothing is offered while reset is held
  assign hs_s       = win_valid_s && (state_r == IDLE) && !rst;
  assign req0_ready = hs_s && !win_s;
  assign req1_ready = hs_s && win_s;

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (hs_s) state_s = EXEC;
        else      state_s = IDLE;
      end
      EXEC: begin
        if (cnt_r == 4'd0) state_s = RESP;
        else               state_s = EXEC;
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register plus registered ALU drive, capture, response and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      cnt_r        <= 4'd0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_s        <= '0;
      rsp_data     <= '0;
      grant_id     <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (hs_s) begin
            alu_a    <= win_s ? req1_a  : req0_a;
            alu_b    <= win_s ? req1_b  : req0_b;
            alu_s    <= win_s ? req1_op : req0_op;
            grant_id <= win_s;
            cnt_r    <= CNT_INIT;
          end
        end
        EXEC: begin
          if (cnt_r != 4'd0) cnt_r    <= cnt_r - 4'd1;
          else               rsp_data <= alu_out;
        end
        RESP:    last_grant_r <= grant_id;
        default: last_grant_r <= last_grant_r;
      endcase
      // grant_id is already settled when entering RESP, so it steers the pulse
      rsp0_valid <= (state_s == RESP) && !grant_id;
      rsp1_valid <= (state_s == RESP) && grant_id;
      busy       <= (state_s != IDLE);
    end
  end

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Directed bench for alu_op_arbiter: scoreboard of expected responses, immediate-assert checks.
module tb_alu_op_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DUT with EXEC_CYCLES=1
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_op, req1_op;
  logic       rsp0_valid, rsp1_valid, busy, grant_id;
  logic [7:0] rsp_data, alu_a, alu_b, alu_out;
  logic [3:0] alu_s;

  // DUT with EXEC_CYCLES=4
  logic       req0_valid_4, req1_valid_4, req0_ready_4, req1_ready_4;
  logic [7:0] req0_a_4, req0_b_4, req1_a_4, req1_b_4;
  logic [3:0] req0_op_4, req1_op_4;
  logic       rsp0_valid_4, rsp1_valid_4, busy_4, grant_id_4;
  logic [7:0] rsp_data_4, alu_a_4, alu_b_4, alu_out_4;
  logic [3:0] alu_s_4;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    case (s)
      4'd0:    return 8'(a + b);
      4'd1:    return 8'(a - b);
      default: return a ^ b;
    endcase
  endfunction

  always_comb alu_out   = alu_ref(alu_a, alu_b, alu_s);
  always_comb alu_out_4 = alu_ref(alu_a_4, alu_b_4, alu_s_4);

  alu_op_arbiter #(.WIDTH(8), .OPW(4), .EXEC_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_out(alu_out),
    .busy(busy), .grant_id(grant_id)
  );

  alu_op_arbiter #(.WIDTH(8), .OPW(4), .EXEC_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid_4), .req0_a(req0_a_4), .req0_b(req0_b_4), .req0_op(req0_op_4), .req0_ready(req0_ready_4),
    .req1_valid(req1_valid_4), .req1_a(req1_a_4), .req1_b(req1_b_4), .req1_op(req1_op_4), .req1_ready(req1_ready_4),
    .rsp0_valid(rsp0_valid_4), .rsp1_valid(rsp1_valid_4), .rsp_data(rsp_data_4),
    .alu_a(alu_a_4), .alu_b(alu_b_4), .alu_s(alu_s_4), .alu_out(alu_out_4),
    .busy(busy_4), .grant_id(grant_id_4)
  );

  typedef struct packed {
    logic       id;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   vecs    = 0;
  int   errs    = 0;
  int   rsp_cnt = 0;
  int   cyc     = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard consumer: every response pulse must match the oldest accepted operation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (rsp0_valid || rsp1_valid)) begin
      rsp_cnt++;
      chk("rsp_onehot", {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
      chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_id", {31'd0, rsp1_valid}, {31'd0, e.id});
        chk("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
      end
    end
  end

  task automatic wait_hs(output logic who, output int at);
    logic got;
    got = 1'b0;
    who = 1'b0;
    at  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) begin
        who = 1'b0; got = 1'b1; at = cyc; break;
      end else if (req1_valid && req1_ready) begin
        who = 1'b1; got = 1'b1; at = cyc; break;
      end
    end
    chk("hs_timeout", {31'd0, got}, 32'd1);
  endtask

  // Wait for a handshake, record the expected result, return just after the accepting edge
  task automatic accept(output logic who, output int at);
    exp_t e;
    wait_hs(who, at);
    e.id   = who;
    e.data = who ? alu_ref(req1_a, req1_b, req1_op) : alu_ref(req0_a, req0_b, req0_op);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin
        done = 1'b1; break;
      end
    end
    chk("drain", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic who;
    int   at, prev, rc, bcnt;
    req0_valid = 1'b0; req0_a = 8'd0; req0_b = 8'd0; req0_op = 4'd0;
    req1_valid = 1'b0; req1_a = 8'd0; req1_b = 8'd0; req1_op = 4'd0;
    req0_valid_4 = 1'b0; req0_a_4 = 8'd0; req0_b_4 = 8'd0; req0_op_4 = 4'd0;
    req1_valid_4 = 1'b0; req1_a_4 = 8'd0; req1_b_4 = 8'd0; req1_op_4 = 4'd0;
    prev = 0;

    // Reset state, with a valid request held to show ready stays low
    #1 rst = 1'b1;
    req0_valid = 1'b1;
    #1;
    chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
    chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_grant", {31'd0, grant_id}, 32'd0);
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    req0_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Contention from reset: grants alternate 0,1,0,1, one handshake every 3 cycles
    req0_a = 8'd3; req0_b = 8'd2; req0_op = 4'd0; req0_valid = 1'b1;
    req1_a = 8'd3; req1_b = 8'd2; req1_op = 4'd1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      accept(who, at);
      chk("grant_order", {31'd0, who}, k % 2);
      if (k > 0) chk("hs_interval", at - prev, 32'd3);
      prev = at;
      chk("grant_id", {31'd0, grant_id}, {31'd0, who});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    // Single request with exact response timing
    @(posedge clk); #1;
    req0_a = 8'd3; req0_b = 8'd2; req0_op = 4'd0; req0_valid = 1'b1;
    accept(who, at);
    req0_valid = 1'b0;
    chk("single_who", {31'd0, who}, 32'd0);
    chk("single_alu_a", {24'd0, alu_a}, 32'd3);
    chk("single_alu_b", {24'd0, alu_b}, 32'd2);
    chk("single_alu_s", {28'd0, alu_s}, 32'd0);
    chk("single_busy", {31'd0, busy}, 32'd1);
    chk("single_no_rsp_yet", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    @(posedge clk); #1;
    chk("single_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd2);
    chk("single_data", {24'd0, rsp_data}, 32'd5);
    @(posedge clk); #1;
    chk("single_pulse_end", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    chk("single_idle", {31'd0, busy}, 32'd0);

    // Reset during EXEC: outputs clear at once, no response, and requester 0 wins the next tie
    req0_op = 4'd1; req0_valid = 1'b1;
    accept(who, at);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rc = rsp_cnt;
    #2 rst = 1'b1;
    #1;
    chk("mid_alu_a", {24'd0, alu_a}, 32'd0);
    chk("mid_alu_s", {28'd0, alu_s}, 32'd0);
    chk("mid_rsp_data", {24'd0, rsp_data}, 32'd0);
    chk("mid_busy_clr", {31'd0, busy}, 32'd0);
    chk("mid_ready", {31'd0, req0_ready}, 32'd0);
    sb.delete();
    req0_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_no_rsp", rsp_cnt, rc);
    req0_op = 4'd0; req0_valid = 1'b1;
    req1_a = 8'd9; req1_b = 8'd4; req1_op = 4'd1; req1_valid = 1'b1;
    accept(who, at);
    chk("post_rst_winner", {31'd0, who}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    // Op sweep 0..8 back-to-back from requester 0
    rc = rsp_cnt;
    @(posedge clk); #1;
    req0_a = 8'd3; req0_b = 8'd2; req0_valid = 1'b1;
    for (int op = 0; op < 9; op++) begin
      req0_op = 4'(op);
      accept(who, at);
    end
    req0_valid = 1'b0;
    drain();
    chk("sweep_count", rsp_cnt - rc, 32'd9);

    // EXEC_CYCLES=4: prime rsp_data with 5, then 255+1 wraps to 0 at edge N+4
    @(posedge clk); #1;
    req1_a_4 = 8'd3; req1_b_4 = 8'd2; req1_op_4 = 4'd0; req1_valid_4 = 1'b1;
    @(negedge clk);
    chk("lat_ready_a", {31'd0, req1_ready_4}, 32'd1);
    @(posedge clk); #1;
    req1_valid_4 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("lat_prime_rsp", {30'd0, rsp0_valid_4, rsp1_valid_4}, 32'd1);
    chk("lat_prime_data", {24'd0, rsp_data_4}, 32'd5);
    @(posedge clk); #1;
    req1_a_4 = 8'd255; req1_b_4 = 8'd1; req1_op_4 = 4'd0; req1_valid_4 = 1'b1;
    @(negedge clk);
    chk("lat_ready_b", {31'd0, req1_ready_4}, 32'd1);
    @(posedge clk); #1;
    req1_valid_4 = 1'b0;
    bcnt = busy_4 ? 1 : 0;
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      if (busy_4) bcnt++;
      chk("lat_hold_data", {24'd0, rsp_data_4}, 32'd5);
      chk("lat_no_rsp", {30'd0, rsp0_valid_4, rsp1_valid_4}, 32'd0);
    end
    @(posedge clk); #1;
    if (busy_4) bcnt++;
    chk("lat_rsp", {30'd0, rsp0_valid_4, rsp1_valid_4}, 32'd1);
    chk("lat_wrap_data", {24'd0, rsp_data_4}, 32'd0);
    @(posedge clk); #1;
    if (busy_4) bcnt++;
    chk("lat_pulse_end", {30'd0, rsp0_valid_4, rsp1_valid_4}, 32'd0);
    // busy covers EXEC and RESP; with the IDLE handshake cycle the operation spans 6 cycles
    chk("lat_busy_cycles", bcnt, 32'd5);

    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
